// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Multi-cycle sequencer for the program-counter datapath.
//                Fetches each instruction from a handshaked instruction
//                memory, then executes it. In the execute cycle it drives
//                the PC-update enable, the branch select and the
//                register-file commit strobe. It also keeps saturating
//                counters of active cycles and retired instructions.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      : width of the cycles / instret counters
//    TIMEOUT    : consecutive non-ready FETCH cycles tolerated; the next
//                 cycle after the TIMEOUT-th one is FAULT (must be >= 1)
//  Ports
//    clk        : system clock, rising edge
//    rst        : asynchronous reset, active low
//    start      : level; leaves IDLE when high (ignored elsewhere)
//    imem_ready : instruction memory holds valid data for the current PC
//    branch     : decoded instruction is a conditional branch
//    eq         : ALU equal/zero flag for the current instruction
//    halt_instr : decoded instruction is ecall/ebreak
//    stall      : external hold request while executing
//    imem_req   : fetch request for the current PC
//    pc_we      : PC register update enable
//    PCsrc      : 0 = PC+4, 1 = PC+ImmOp (forced 0 when pc_we is 0)
//    commit_en  : register-file write enable gate
//    halted     : high while in HALT
//    fault      : high while in FAULT (fetch timeout)
//    state      : encoded FSM state (IDLE=0 FETCH=1 EXEC=2 HALT=3 FAULT=4)
//    cycles     : saturating count of FETCH/EXEC cycles
//    instret    : saturating count of retired instructions
// ============================================================================
module pc_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             imem_ready,
    input  logic             branch,
    input  logic             eq,
    input  logic             halt_instr,
    input  logic             stall,
    output logic             imem_req,
    output logic             pc_we,
    output logic             PCsrc,
    output logic             commit_en,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [WIDTH-1:0] cycles,
    output logic [WIDTH-1:0] instret
);

    // Wait counter only has to hold 0 .. TIMEOUT-1.
    localparam int c_WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic [WIDTH-1:0]    r_cycles;
    logic [WIDTH-1:0]    r_instret;

    logic w_commit;
    logic w_active;

    // ------------------------------------------------------------------
    // State, wait counter and event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_cycles   <= '0;
            r_instret  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;

            // Both counters stick at all-ones instead of wrapping.
            if (w_active && !(&r_cycles)) begin
                r_cycles <= r_cycles + WIDTH'(1);
            end
            // A saturated instret does not block the commit itself.
            if (w_commit && !(&r_instret)) begin
                r_instret <= r_instret + WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = '0;
        w_commit    = 1'b0;
        w_active    = 1'b0;
        imem_req    = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req = 1'b1;
                w_active = 1'b1;
                if (imem_ready) begin
                    // Zero wait states are legal: ready in the first
                    // FETCH cycle moves straight on.
                    w_state_nxt = S_EXEC;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    // This is the TIMEOUT-th non-ready cycle in a row.
                    w_state_nxt = S_FAULT;
                end else begin
                    w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
                end
            end

            S_EXEC: begin
                w_active = 1'b1;
                // Stall outranks both halt and branch; a halting
                // instruction never commits and leaves the PC on itself.
                if (stall) begin
                    w_state_nxt = S_EXEC;
                end else if (halt_instr) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            S_FAULT: begin
                fault = 1'b1;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // PCsrc is gated by the commit so it is 0 whenever pc_we is 0.
    assign pc_we     = w_commit;
    assign commit_en = w_commit;
    assign PCsrc     = w_commit & branch & eq;
    assign state     = r_state;
    assign cycles    = r_cycles;
    assign instret   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Testbench for pc_sequencer. Instructions are described as
//                transactions (wait states, stall cycles, halt, branch, eq);
//                the driver plays them cycle by cycle and a reference model
//                computes the expected commit / halt / fault events with
//                plain arithmetic. A monitor compares these events as the
//                DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int WIDTH   = 6;
    localparam int TIMEOUT = 15;
    localparam int MAXV    = (1 << WIDTH) - 1;

    localparam logic [1:0] K_COMMIT = 2'd0;
    localparam logic [1:0] K_HALT   = 2'd1;
    localparam logic [1:0] K_FAULT  = 2'd2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             imem_ready = 1'b0;
    logic             branch = 1'b0;
    logic             eq = 1'b0;
    logic             halt_instr = 1'b0;
    logic             stall = 1'b0;
    logic             imem_req;
    logic             pc_we;
    logic             PCsrc;
    logic             commit_en;
    logic             halted;
    logic             fault;
    logic [2:0]       state;
    logic [WIDTH-1:0] cycles;
    logic [WIDTH-1:0] instret;

    pc_sequencer #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_ready (imem_ready),
        .branch     (branch),
        .eq         (eq),
        .halt_instr (halt_instr),
        .stall      (stall),
        .imem_req   (imem_req),
        .pc_we      (pc_we),
        .PCsrc      (PCsrc),
        .commit_en  (commit_en),
        .halted     (halted),
        .fault      (fault),
        .state      (state),
        .cycles     (cycles),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] kind;
        logic       pcsrc;
        logic [31:0] ret;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: counts of active cycles and retired instructions.
    int m_total = 0;
    int m_ret   = 0;

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: consumes expected events as the DUT presents them
    // ------------------------------------------------------------------
    bit seen_end = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            seen_end = 1'b0;
        end else begin
            if (pc_we || commit_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_commit: got pc_we=%0d commit_en=%0d expected no commit at %0t",
                             pc_we, commit_en, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_kind",    int'(K_COMMIT), int'(e.kind));
                    chk("commit_pc_we",   int'(pc_we), 1);
                    chk("commit_en",      int'(commit_en), 1);
                    chk("commit_pcsrc",   int'(PCsrc), int'(e.pcsrc));
                    chk("commit_instret", int'(instret), int'(e.ret));
                    chk("commit_cycles",  int'(cycles), int'(e.cyc));
                    chk("commit_state",   int'(state), 2);
                end
            end else begin
                chk("pcsrc_without_we", int'(PCsrc), 0);
            end

            if ((halted || fault) && !seen_end) begin
                seen_end = 1'b1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_end: got halted=%0d fault=%0d expected none at %0t",
                             halted, fault, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("end_halted",  int'(halted), (e.kind == K_HALT) ? 1 : 0);
                    chk("end_fault",   int'(fault), (e.kind == K_FAULT) ? 1 : 0);
                    chk("end_state",   int'(state), (e.kind == K_HALT) ? 3 : 4);
                    chk("end_instret", int'(instret), int'(e.ret));
                    chk("end_cycles",  int'(cycles), int'(e.cyc));
                end
            end else if (seen_end) begin
                chk("imem_req_after_end", int'(imem_req), 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        start      = 1'b0;
        imem_ready = 1'b0;
        branch     = 1'b0;
        eq         = 1'b0;
        halt_instr = 1'b0;
        stall      = 1'b0;
        step();
        step();
        chk("rst_state",     int'(state), 0);
        chk("rst_imem_req",  int'(imem_req), 0);
        chk("rst_pc_we",     int'(pc_we), 0);
        chk("rst_commit_en", int'(commit_en), 0);
        chk("rst_halted",    int'(halted), 0);
        chk("rst_fault",     int'(fault), 0);
        chk("rst_cycles",    int'(cycles), 0);
        chk("rst_instret",   int'(instret), 0);
        rst     = 1'b1;
        m_total = 0;
        m_ret   = 0;
        exp_q.delete();
    endtask

    // Called in IDLE; returns in the first FETCH cycle.
    task automatic begin_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called in a FETCH cycle; returns in the following FETCH or HALT cycle.
    task automatic run_instr(input int w, input int s, input bit hlt,
                             input bit br, input bit e);
        exp_t x;
        for (int i = 0; i < w; i++) begin
            imem_ready = 1'b0;
            stall      = 1'($urandom);
            halt_instr = 1'($urandom);
            branch     = 1'($urandom);
            start      = 1'($urandom);
            step();
        end
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        for (int i = 0; i < s; i++) begin
            stall      = 1'b1;
            halt_instr = 1'($urandom);
            branch     = 1'($urandom);
            eq         = 1'($urandom);
            start      = 1'($urandom);
            step();
        end
        stall      = 1'b0;
        halt_instr = hlt;
        branch     = br;
        eq         = e;
        x.pcsrc    = 1'b0;
        if (!hlt) begin
            x.kind  = K_COMMIT;
            x.pcsrc = br & e;
            x.ret   = 32'(sat(m_ret));
            x.cyc   = 32'(sat(m_total + w + 1 + s));
            m_ret   = m_ret + 1;
            m_total = m_total + w + s + 2;
        end else begin
            m_total = m_total + w + s + 2;
            x.kind  = K_HALT;
            x.ret   = 32'(sat(m_ret));
            x.cyc   = 32'(sat(m_total));
        end
        exp_q.push_back(x);
        step();
        halt_instr = 1'b0;
        branch     = 1'b0;
        eq         = 1'b0;
        start      = 1'b0;
    endtask

    // Called in a FETCH cycle; memory never answers.
    task automatic run_fault();
        exp_t x;
        for (int i = 0; i < TIMEOUT; i++) begin
            imem_ready = 1'b0;
            step();
        end
        m_total = m_total + TIMEOUT;
        x.kind  = K_FAULT;
        x.pcsrc = 1'b0;
        x.ret   = 32'(sat(m_ret));
        x.cyc   = 32'(sat(m_total));
        exp_q.push_back(x);
        // FAULT must hold against start and ready.
        for (int i = 0; i < 4; i++) begin
            start      = 1'b1;
            imem_ready = 1'b1;
            step();
        end
        start      = 1'b0;
        imem_ready = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (3) step();
        chk(name, exp_q.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Run A: four zero-wait sequential instructions, then halt.
        do_reset();
        begin_run();
        for (int i = 0; i < 4; i++) run_instr(0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(0, 0, 1'b1, 1'b0, 1'b0);
        settle("run_a_pending");

        // Run B: branches, waits (incl. TIMEOUT-1), stalls with halt
        // pending, and enough instructions to saturate both counters.
        do_reset();
        begin_run();
        run_instr(0, 0, 1'b0, 1'b1, 1'b1);
        run_instr(0, 0, 1'b0, 1'b1, 1'b0);
        run_instr(3, 0, 1'b0, 1'b0, 1'b1);
        run_instr(TIMEOUT - 1, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 66; i++) begin
            run_instr(($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), 1'b0,
                      1'($urandom), 1'($urandom));
        end
        run_instr(1, 2, 1'b1, 1'b1, 1'b1);
        settle("run_b_pending");

        // Run C: a couple of instructions, then a fetch timeout.
        do_reset();
        begin_run();
        run_instr(2, 1, 1'b0, 1'b1, 1'b1);
        run_instr(TIMEOUT - 1, 0, 1'b0, 1'b0, 1'b0);
        run_fault();
        settle("run_c_pending");

        // Run D: reset asserted in the middle of a committing EXEC cycle.
        do_reset();
        begin_run();
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        stall      = 1'b0;
        halt_instr = 1'b0;
        #1;
        chk("pre_reset_pc_we", int'(pc_we), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_pc_we",     int'(pc_we), 0);
        chk("async_rst_commit_en", int'(commit_en), 0);
        chk("async_rst_state",     int'(state), 0);
        chk("async_rst_cycles",    int'(cycles), 0);
        chk("async_rst_instret",   int'(instret), 0);
        step();
        rst     = 1'b1;
        m_total = 0;
        m_ret   = 0;
        exp_q.delete();
        // Restart from FETCH after the reset.
        begin_run();
        chk("restart_state", int'(state), 1);
        run_instr(1, 1, 1'b0, 1'b1, 1'b1);
        run_instr(0, 2, 1'b1, 1'b0, 1'b0);
        settle("run_d_pending");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle controller for the program-counter datapath: PC register, next-PC mux and immediate-branch path.
- Sequences instruction fetch against a handshaked instruction memory.
- Generates the PC-update enable, the branch-select (PCsrc) and the register-file commit strobe; counts cycles and retired instructions.
- Sits between the control decoder and the PC unit; the PC unit updates only when pc_we is high.

Parameters:
- WIDTH, 32, data and counter width.
- TIMEOUT, 15, maximum wait cycles for imem_ready before fault; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin execution from IDLE (level, sampled each cycle)
- imem_ready  input  1  instruction memory has valid data for current PC
- branch  input  1  decoded instruction is a conditional branch
- eq  input  1  ALU zero/equal flag for current instruction
- halt_instr  input  1  decoded instruction is ecall/ebreak
- stall  input  1  external hold request during execute
- imem_req  output  1  fetch request for current PC
- pc_we  output  1  PC register update enable
- PCsrc  output  1  0 = PC+4, 1 = PC+ImmOp; meaningful only when pc_we=1
- commit_en  output  1  register-file write enable gate
- halted  output  1  sticky, in HALT state
- fault  output  1  sticky, fetch timeout occurred
- state  output  3  encoded FSM state for debug
- cycles  output  WIDTH  active cycle counter
- instret  output  WIDTH  retired instruction counter

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE; all outputs 0; counters 0; wait counter 0.
  - Release is synchronous to the next clk edge.
- State encoding: IDLE=0, FETCH=1, EXEC=2, HALT=3, FAULT=4.
- IDLE:
  - All strobes 0.
  - start=1 → FETCH next cycle.
- FETCH:
  - imem_req=1.
  - imem_ready=1 → EXEC next cycle. Wait counter clears. A same-cycle ready (0 wait states) is legal.
  - imem_ready=0 → wait counter +1.
  - When the wait counter reaches TIMEOUT with ready still 0 → FAULT next cycle. TIMEOUT=15 means FAULT is entered after the 15th consecutive non-ready FETCH cycle.
- EXEC (all outputs combinational from state and inputs):
  - stall=1 → pc_we=0, commit_en=0; remain in EXEC; instret unchanged. Stall has priority over halt_instr and branch.
  - stall=0, halt_instr=1 → pc_we=0, commit_en=0; → HALT. halt_instr is not counted in instret; PC stays at the halting instruction.
  - stall=0, halt_instr=0 → pc_we=1, commit_en=1, PCsrc=branch & eq; instret +1; → FETCH.
  - PCsrc=0 whenever pc_we=0.
- HALT: halted=1, all strobes 0. Only reset exits.
- FAULT: fault=1, all strobes 0. Only reset exits. halted stays 0.
- cycles:
  - Increments every clk while in FETCH or EXEC.
  - Saturates at all-ones and does not wrap.
- instret: saturates at all-ones. When saturated, commit still proceeds.
- start is ignored outside IDLE.
- No outputs are registered beyond state and counters.
- Latency: minimum 2 cycles per instruction (FETCH + EXEC) with zero-wait memory.
- Reset asserted mid-EXEC: no commit occurs in that cycle. Outputs drop immediately (asynchronously).

Test Plan:
- Reset, then start=1 with imem_ready tied 1 and branch=0 for 4 instructions → states alternate 1,2; pc_we pulses on cycles 2,4,6,8 after start; PCsrc=0; instret=4, cycles=8.
- Branch in EXEC with branch=1, eq=1 → pc_we=1, PCsrc=1; with eq=0 → PCsrc=0; instret increments in both cases.
- imem_ready held 0 for 3 cycles, then 1 → imem_req high 4 cycles, no fault, EXEC entered on the 5th cycle. Ready held 0 for 15 cycles → fault=1, state=4, imem_req=0 thereafter.
- Stall held 2 cycles in EXEC with halt_instr=1 → pc_we=0 and commit_en=0 for 2 cycles, state stays 2; then stall=0 → HALT, halted=1, instret unchanged.
- Reset pulse (rst=0) mid-EXEC with stall=0 → pc_we and commit_en drop in the same cycle; state=0; counters=0; a new start resumes from FETCH.
- Preload-free saturation (force TIMEOUT path off, run with small-WIDTH build WIDTH=4) → cycles stops at 15; instret stops at 15 while pc_we still pulses.
